p17_sie_rx: RTL

Receive-side packet decoder of the serial interface engine, directly downstream of the full-speed PHY receiver. It consumes the PHY's byte/EOP/error strobes and validates each packet's PID. It checks CRC5 on tokens and CRC16 on data packets, and checks packet length. It reports decoded token fields, streams data payload bytes with the CRC bytes stripped, and issues a single end-of-packet verdict per packet.

---
 rtl/p17_sie_rx.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/p17_sie_rx.sv
// p17_sie_rx: receive-side packet decoder of the serial interface engine.
// It takes the PHY byte/EOP/error strobes and validates the PID. Tokens are
// checked with CRC5 and data packets with CRC16. Token fields are reported,
// payload bytes are streamed with the two CRC bytes stripped, and exactly one
// end-of-packet verdict is issued per packet. usb_reset_i acts as a
// synchronous clear of the whole decoder.
module p17_sie_rx #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_err_i,
    input  logic        rx_ready_i,
    input  logic        usb_reset_i,
    output logic [3:0]  pid_o,
    output logic [6:0]  addr_o,
    output logic [3:0]  endp_o,
    output logic [10:0] frame_o,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        pkt_end_o,
    output logic        pkt_ok_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TOKEN   = 3'd1,
        S_DATA    = 3'd2,
        S_HSK     = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    localparam logic [10:0] PLEN_MAX = 11'(MAX_PAYLOAD);
    localparam logic [10:0] PLEN_SAT = 11'(MAX_PAYLOAD + 1);

    // CRC5 over one byte, LSB first on the wire
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
        logic [4:0] c;
        logic       fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    // CRC16 over one byte, LSB first on the wire
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [10:0] r_tok, w_tok_nxt;          // token bits 10:0; the CRC bits are only fed to CRC5
    logic [4:0]  r_crc5, w_crc5_nxt;
    logic [15:0] r_crc16, w_crc16_nxt;
    logic [7:0]  r_h0, w_h0_nxt;            // oldest byte in the holding pipe
    logic [7:0]  r_h1, w_h1_nxt;            // newest byte in the holding pipe
    logic [1:0]  r_bcnt, w_bcnt_nxt;        // post-PID bytes: token count / pipe fill
    logic [10:0] r_plen, w_plen_nxt;        // payload bytes emitted, saturating
    logic [3:0]  r_pid, w_pid_nxt;
    logic [6:0]  r_addr, w_addr_nxt;
    logic [3:0]  r_endp, w_endp_nxt;
    logic [10:0] r_frame, w_frame_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_dvalid, w_dvalid_nxt;
    logic        r_end, w_end_nxt;
    logic        r_ok, w_ok_nxt;

    logic        w_byte, w_eop, w_err;
    logic [4:0]  w_crc5_upd;
    logic [15:0] w_crc16_upd;

    assign w_byte      = rx_ready_i & rx_valid_i & ~rx_err_i;
    assign w_eop       = rx_ready_i & ~rx_valid_i & ~rx_err_i;
    assign w_err       = rx_ready_i & rx_err_i;
    assign w_crc5_upd  = crc5_byte(r_crc5, rx_data_i);
    assign w_crc16_upd = crc16_byte(r_crc16, rx_data_i);

    // Next-state, datapath and registered-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_tok_nxt    = r_tok;
        w_crc5_nxt   = r_crc5;
        w_crc16_nxt  = r_crc16;
        w_h0_nxt     = r_h0;
        w_h1_nxt     = r_h1;
        w_bcnt_nxt   = r_bcnt;
        w_plen_nxt   = r_plen;
        w_pid_nxt    = r_pid;
        w_addr_nxt   = r_addr;
        w_endp_nxt   = r_endp;
        w_frame_nxt  = r_frame;
        w_data_nxt   = r_data;
        w_dvalid_nxt = 1'b0;
        w_end_nxt    = 1'b0;
        w_ok_nxt     = 1'b0;
        if (usb_reset_i) begin
            // bus reset: drop any packet silently and clear every field
            w_state_nxt = S_IDLE;
            w_tok_nxt   = 11'h000;
            w_crc5_nxt  = 5'h1F;
            w_crc16_nxt = 16'hFFFF;
            w_h0_nxt    = 8'h00;
            w_h1_nxt    = 8'h00;
            w_bcnt_nxt  = 2'd0;
            w_plen_nxt  = 11'd0;
            w_pid_nxt   = 4'h0;
            w_addr_nxt  = 7'h00;
            w_endp_nxt  = 4'h0;
            w_frame_nxt = 11'h000;
            w_data_nxt  = 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // per-packet state is re-armed while waiting for a PID
                    w_crc5_nxt  = 5'h1F;
                    w_crc16_nxt = 16'hFFFF;
                    w_bcnt_nxt  = 2'd0;
                    w_plen_nxt  = 11'd0;
                    if (w_byte) begin
                        if (rx_data_i[7:4] != ~rx_data_i[3:0]) begin
                            w_state_nxt = S_DISCARD;
                        end else begin
                            w_pid_nxt = rx_data_i[3:0];
                            case (rx_data_i[1:0])
                                2'b11:   w_state_nxt = S_DATA;
                                2'b10:   w_state_nxt = S_HSK;
                                default: w_state_nxt = S_TOKEN;
                            endcase
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_TOKEN: begin
                    if (w_err) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_eop) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                        if ((r_bcnt == 2'd2) && (r_crc5 == 5'h0C)) begin
                            w_ok_nxt   = 1'b1;
                            w_addr_nxt = r_tok[6:0];
                            w_endp_nxt = r_tok[10:7];
                            if (r_pid == 4'h5) begin
                                w_frame_nxt = r_tok[10:0];
                            end else begin
                                w_frame_nxt = r_frame;
                            end
                        end else begin
                            w_ok_nxt = 1'b0;
                        end
                    end else if (w_byte) begin
                        if (r_bcnt == 2'd2) begin
                            w_state_nxt = S_DISCARD;
                        end else begin
                            if (r_bcnt == 2'd0) begin
                                w_tok_nxt = {r_tok[10:8], rx_data_i};
                            end else begin
                                w_tok_nxt = {rx_data_i[2:0], r_tok[7:0]};
                            end
                            w_crc5_nxt = w_crc5_upd;
                            w_bcnt_nxt = r_bcnt + 2'd1;
                        end
                    end else begin
                        w_state_nxt = S_TOKEN;
                    end
                end
                S_DATA: begin
                    if (w_err) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_eop) begin
                        // the two bytes still in the pipe are the CRC
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_ok_nxt    = (r_bcnt == 2'd2) && (r_crc16 == 16'h800D) && (r_plen <= PLEN_MAX);
                    end else if (w_byte) begin
                        w_crc16_nxt = w_crc16_upd;
                        if (r_bcnt == 2'd2) begin
                            w_dvalid_nxt = 1'b1;
                            w_data_nxt   = r_h0;
                            w_plen_nxt   = (r_plen == PLEN_SAT) ? r_plen : (r_plen + 11'd1);
                        end else begin
                            w_bcnt_nxt = r_bcnt + 2'd1;
                        end
                        w_h0_nxt = r_h1;
                        w_h1_nxt = rx_data_i;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_HSK: begin
                    if (w_err) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_eop) begin
                        w_end_nxt   = 1'b1;
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_byte) begin
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_state_nxt = S_HSK;
                    end
                end
                S_DISCARD: begin
                    if (w_err || w_eop) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tok    <= 11'h000;
            r_crc5   <= 5'h1F;
            r_crc16  <= 16'hFFFF;
            r_h0     <= 8'h00;
            r_h1     <= 8'h00;
            r_bcnt   <= 2'd0;
            r_plen   <= 11'd0;
            r_pid    <= 4'h0;
            r_addr   <= 7'h00;
            r_endp   <= 4'h0;
            r_frame  <= 11'h000;
            r_data   <= 8'h00;
            r_dvalid <= 1'b0;
            r_end    <= 1'b0;
            r_ok     <= 1'b0;
        end else begin
            r_tok    <= w_tok_nxt;
            r_crc5   <= w_crc5_nxt;
            r_crc16  <= w_crc16_nxt;
            r_h0     <= w_h0_nxt;
            r_h1     <= w_h1_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_plen   <= w_plen_nxt;
            r_pid    <= w_pid_nxt;
            r_addr   <= w_addr_nxt;
            r_endp   <= w_endp_nxt;
            r_frame  <= w_frame_nxt;
            r_data   <= w_data_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_end    <= w_end_nxt;
            r_ok     <= w_ok_nxt;
        end
    end

    assign pid_o        = r_pid;
    assign addr_o       = r_addr;
    assign endp_o       = r_endp;
    assign frame_o      = r_frame;
    assign data_o       = r_data;
    assign data_valid_o = r_dvalid;
    assign pkt_end_o    = r_end;
    assign pkt_ok_o     = r_ok;

endmodule
